// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync/vsync/de/sof and pixel/line coordinates,
// advancing one pixel per clk cycle on which pclk_ena is high.
// Optional colour-bar test pattern output enabled by defining VTG_PATTERN_EN.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pclk_ena,
    input  logic             enable,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             sof,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt
`ifdef VTG_PATTERN_EN
    ,
    output logic [23:0]      pat_rgb
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             sof_q, sof_d;

    // Next-state position: idle when stopped, advance on pixel enable, else hold.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!enable) begin
            hcnt_d = H_LAST;
            vcnt_d = V_LAST;
        end else if (pclk_ena) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + ONE;
            end else begin
                hcnt_d = hcnt_q + ONE;
            end
        end
    end

    // Decodes from the next-state position so registered outputs stay aligned.
    always_comb begin
        de_d    = (hcnt_d < H_ACT_C) && (vcnt_d < V_ACT_C);
        hsync_d = ((hcnt_d >= HS_START) && (hcnt_d < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d = ((vcnt_d >= VS_START) && (vcnt_d < VS_END)) ? VS_POL : ~VS_POL;
        sof_d   = (hcnt_d == '0) && (vcnt_d == '0);
    end

    // Position and timing output registers; reset lands in the back porch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q  <= H_LAST;
            vcnt_q  <= V_LAST;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            sof_q   <= sof_d;
        end
    end

    assign hcnt  = hcnt_q;
    assign vcnt  = vcnt_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign sof   = sof_q;

`ifdef VTG_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    logic [CNT_W-1:0] bar_px_q, bar_px_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [23:0]      pat_q, pat_d;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Bar sub-counter tracks the pixel within the current bar; restarts each line.
    // Past the active area the index keeps wrapping but de masks the colour.
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (!enable) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (pclk_ena) begin
            if (hcnt_d == '0) begin
                bar_px_d  = '0;
                bar_idx_d = '0;
            end else if (bar_px_q == BAR_LAST) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d = bar_px_q + ONE;
            end
        end
        pat_d = de_d ? bar_colour(bar_idx_d) : 24'h000000;
    end

    // Pattern registers, aligned with de.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
        end else begin
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
        end
    end

    assign pat_rgb = pat_q;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator that sits directly downstream of the video clock generator.
- Runs on the fast system clock and advances one pixel per cycle on which `pclk_ena` is high.
- Produces hsync, vsync, data-enable, start-of-frame and pixel/line coordinates for the pixel pipeline and the output PHY.
- All timing is parameterised. Defaults give 640x480@60.

Parameters:
- H_ACTIVE, 640, active pixels per line (must be a multiple of 8)
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- CNT_W, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- pclk_ena  input  1  pixel-rate enable from the clock generator
- enable  input  1  run/stop control; level-sensitive
- hsync  output  1  horizontal sync, polarity per HS_POL
- vsync  output  1  vertical sync, polarity per VS_POL
- de  output  1  data enable, high in the active area
- sof  output  1  start of frame, high while position = (0,0)
- hcnt  output  CNT_W  current pixel column
- vcnt  output  CNT_W  current line

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Region order on both axes: active, front porch, sync, back porch.
- Idle/reset state (async rst_n low):
  - hcnt = H_TOTAL-1, vcnt = V_TOTAL-1.
  - de = 0, sof = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - This state is self-consistent: the position sits in the back porch, so syncs are inactive and de is low.
- Advance condition: enable=1 and pclk_ena=1.
  - hcnt increments.
  - At hcnt = H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - At hcnt = H_TOTAL-1 with vcnt = V_TOTAL-1, both wrap to 0.
- pclk_ena=0 with enable=1: all outputs hold their values.
- enable=0: on the next clk edge, regardless of pclk_ena, return synchronously to the idle state.
- Restart: after enable returns high, the first advance lands on (0,0). Frames always start cleanly.
- Output alignment: all outputs are registered. Decodes are computed from the next-state counters, so hsync, vsync, de and sof always describe the same hcnt/vcnt presented in the same cycle. Zero-cycle skew between outputs.
- Decodes:
  - de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - hsync is active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC. It changes only together with hcnt returning to 0.
  - sof = (hcnt==0 && vcnt==0). It lasts one pixel period, i.e. 2 clk cycles with a /2 pclk_ena.
- Width rules: comparisons use CNT_W-bit unsigned arithmetic. Parameter-derived constants are computed at elaboration time; there is no runtime arithmetic overflow.
- Async reset asserted mid-frame: all outputs take their idle values immediately. On release, the block behaves as after power-up.

Optional Feature:
- Macro: VTG_PATTERN_EN.
- When defined:
  - Adds output `pat_rgb` [23:0], registered and aligned with de.
  - Pattern is 8 vertical colour bars, each H_ACTIVE/8 pixels wide, in this order:
    - FFFFFF
    - FFFF00
    - 00FFFF
    - 00FF00
    - FF00FF
    - FF0000
    - 0000FF
    - 000000
  - The bar index comes from a bar-width sub-counter; no divider.
  - pat_rgb = 0 whenever de = 0 and in the idle state.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
All scenarios use small parameters: H 16/2/3/3 (H_TOTAL=24), V 4/1/2/1 (V_TOTAL=8), pclk_ena toggling every other clk, enable=1.
- Reset release, then the first pclk_ena pulse -> hcnt=0, vcnt=0, de=1, sof=1 for 2 clk. de is high for exactly 16 pixel ticks per active line and low on lines 4–7.
- Horizontal sync -> hsync=0 for hcnt 18..20 (3 ticks), repeating every 24 ticks. It stays inactive at hcnt 21..23 and 0..17.
- Vertical sync and frame -> vsync=0 for vcnt 5..6 (48 ticks), with both edges coincident with hcnt=0. sof recurs every 192 ticks. vcnt wraps 7->0 together with hcnt 23->0.
- Hold pclk_ena=0 for 10 clk mid-line at hcnt=7 -> all outputs are unchanged. On the next pclk_ena, hcnt=8.
- Stall and reset:
  - Drop enable at (hcnt=10, vcnt=2) -> next clk gives hcnt=23, vcnt=7, de=0, hsync=1, vsync=1.
  - Re-raise enable -> the first tick gives (0,0) with sof=1.
  - Assert rst_n low asynchronously mid-frame -> same idle values with no clock edge.
- With VTG_PATTERN_EN defined -> on line 0:
  - pat_rgb = FFFFFF at hcnt 0–1, FFFF00 at hcnt 2–3, 000000 at hcnt 14–15.
  - pat_rgb = 0 at hcnt 16–23 and throughout line 5.
